// File: rtl/cipher_output_holder.sv
// Output holder stage of the stream cipher: XORs one captured data word with one
// keystream word (or bypasses it) and holds the result until the interface FSM idles.

package types_pkg;
    typedef enum logic [1:0] {
        I_IDLE       = 2'b00,
        I_PROCESSING = 2'b01,
        I_DONE       = 2'b10
    } interface_state_t;
endpackage

module cipher_output_holder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  types_pkg::interface_state_t interface_state_in,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        encrypt_en,
    input  logic                        ks_valid,
    input  logic [DATA_W-1:0]           ks_data,
    output logic                        ks_req,
    output logic                        output_is_ready,
    output logic [DATA_W-1:0]           data_out,
    output logic [CNT_W-1:0]            word_count
);
    import types_pkg::*;

    localparam logic [1:0] H_IDLE    = 2'b00;
    localparam logic [1:0] H_WAIT_KS = 2'b01;
    localparam logic [1:0] H_HOLD    = 2'b10;

    logic [1:0]        state;
    logic [DATA_W-1:0] data_reg;

    // NOTE: every register here is updated with <= so all flops sample the
    // pre-edge values; blocking assignments would make the result order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= H_IDLE;
            data_reg        <= '0;
            ks_req          <= 1'b0;
            output_is_ready <= 1'b0;
            data_out        <= '0;
            word_count      <= '0;
        end else begin
            case (state)
                H_IDLE: begin
                    if (interface_state_in == I_PROCESSING) begin
                        if (encrypt_en) begin
                            data_reg <= data_in;
                            ks_req   <= 1'b1;
                            state    <= H_WAIT_KS;
                        end else begin
                            data_out        <= data_in;
                            output_is_ready <= 1'b1;
                            word_count      <= word_count + 1'b1;
                            state           <= H_HOLD;
                        end
                    end
                end

                H_WAIT_KS: begin
                    // Abort wins over a keystream word arriving on the same edge.
                    if (interface_state_in != I_PROCESSING) begin
                        ks_req <= 1'b0;
                        state  <= H_IDLE;
                    end else if (ks_valid && ks_req) begin
                        data_out        <= data_reg ^ ks_data;
                        output_is_ready <= 1'b1;
                        ks_req          <= 1'b0;
                        word_count      <= word_count + 1'b1;
                        state           <= H_HOLD;
                    end
                end

                H_HOLD: begin
                    // Only a true I_IDLE releases; I_DONE and 2'b11 keep the hold.
                    if (interface_state_in == I_IDLE) begin
                        output_is_ready <= 1'b0;
                        state           <= H_IDLE;
                    end
                end

                default: begin
                    ks_req          <= 1'b0;
                    output_is_ready <= 1'b0;
                    state           <= H_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_output_holder.sv
// Scoreboard bench for cipher_output_holder: stimulus pushes expected results,
// a monitor pops and compares on each rising output_is_ready.

module tb_cipher_output_holder;
    import types_pkg::*;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    interface_state_t if_state;
    logic [7:0]       data_in;
    logic             encrypt_en;
    logic             ks_valid;
    logic [7:0]       ks_data;

    logic        ks_req, ready;
    logic [7:0]  data_out;
    logic [15:0] word_count;
    logic        ks_req4, ready4;
    logic [7:0]  data_out4;
    logic [3:0]  word_count4;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    cipher_output_holder dut (
        .clk(clk), .rst(rst), .interface_state_in(if_state), .data_in(data_in),
        .encrypt_en(encrypt_en), .ks_valid(ks_valid), .ks_data(ks_data),
        .ks_req(ks_req), .output_is_ready(ready), .data_out(data_out),
        .word_count(word_count)
    );

    cipher_output_holder #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .interface_state_in(if_state), .data_in(data_in),
        .encrypt_en(encrypt_en), .ks_valid(ks_valid), .ks_data(ks_data),
        .ks_req(ks_req4), .output_is_ready(ready4), .data_out(data_out4),
        .word_count(word_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected result for one completed transaction goes on the scoreboard.
    task automatic expect_word(input logic [7:0] d);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.data = d;
        e.cnt  = exp_count;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, ready, 1'b1);
    endtask

    task automatic release_hold();
        if_state = I_DONE;
        ks_valid = 1'b0;
        tick();
        if_state = I_IDLE;
        tick();
        check("release_ready", ready, 1'b0);
    endtask

    task automatic do_txn(input logic [7:0] d, input logic enc, input logic [7:0] ks);
        data_in    = d;
        encrypt_en = enc;
        ks_valid   = enc;
        ks_data    = ks;
        if_state   = I_PROCESSING;
        expect_word(enc ? (d ^ ks) : d);
        tick();
        wait_ready("txn");
        release_hold();
    endtask

    // Monitor: compare every new result against the scoreboard head.
    initial begin
        logic prev_ready = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready && !prev_ready) begin
                check("sb_nonempty", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("mon_data_out", data_out, e.data);
                    check("mon_word_count", word_count, e.cnt);
                    check("mon_data_out_w4", data_out4, e.data);
                    check("mon_word_count_w4", word_count4, e.cnt[3:0]);
                end
            end
            prev_ready = ready;
        end
    end

    initial begin
        rst        = 1'b1;
        if_state   = I_IDLE;
        data_in    = 8'h00;
        encrypt_en = 1'b0;
        ks_valid   = 1'b0;
        ks_data    = 8'h00;
        exp_count  = 16'd0;
        tick();
        tick();
        check("rst_ks_req", ks_req, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_word_count", word_count, 16'd0);
        rst = 1'b0;
        tick();

        // Encrypt: A5 ^ 3C = 99, keystream valid on the second cycle.
        data_in    = 8'hA5;
        encrypt_en = 1'b1;
        if_state   = I_PROCESSING;
        expect_word(8'h99);
        tick();
        check("enc_ks_req_on", ks_req, 1'b1);
        check("enc_ready_low", ready, 1'b0);
        ks_valid = 1'b1;
        ks_data  = 8'h3C;
        tick();
        check("enc_ks_req_off", ks_req, 1'b0);
        check("enc_ready", ready, 1'b1);

        // Hold: inputs wiggle while I_DONE, result must not move.
        if_state = I_DONE;
        for (int i = 0; i < 3; i++) begin
            data_in    = 8'(i * 37);
            ks_valid   = ~ks_valid;
            encrypt_en = ~encrypt_en;
            tick();
            check("hold_data_out", data_out, 8'h99);
            check("hold_ready", ready, 1'b1);
            check("hold_ks_req", ks_req, 1'b0);
        end
        if_state = I_IDLE;
        ks_valid = 1'b0;
        tick();
        check("rel_ready", ready, 1'b0);
        check("rel_data_kept", data_out, 8'h99);

        // Keystream stall, with late data_in/encrypt_en changes that must be ignored.
        data_in    = 8'h0F;
        encrypt_en = 1'b1;
        if_state   = I_PROCESSING;
        expect_word(8'hF0);
        tick();
        data_in    = 8'h77;
        encrypt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_ks_req", ks_req, 1'b1);
            check("stall_ready", ready, 1'b0);
            tick();
        end
        ks_valid = 1'b1;
        ks_data  = 8'hFF;
        tick();
        check("stall_done", ready, 1'b1);
        release_hold();

        // Bypass: result one cycle later, no keystream request.
        data_in    = 8'h5A;
        encrypt_en = 1'b0;
        if_state   = I_PROCESSING;
        expect_word(8'h5A);
        tick();
        check("byp_ready", ready, 1'b1);
        check("byp_ks_req", ks_req, 1'b0);
        if_state = interface_state_t'(2'b11);
        tick();
        check("byp_11_holds", ready, 1'b1);
        check("byp_11_ks_req", ks_req, 1'b0);
        if_state = I_IDLE;
        tick();
        check("byp_rel", ready, 1'b0);
        check("byp_data_kept", data_out, 8'h5A);

        // 2'b11 in idle does not start a transaction.
        if_state   = interface_state_t'(2'b11);
        encrypt_en = 1'b1;
        tick();
        tick();
        check("idle_11_ks_req", ks_req, 1'b0);
        check("idle_11_ready", ready, 1'b0);

        // Abort with a simultaneous ks_valid: nothing counted.
        data_in    = 8'h11;
        encrypt_en = 1'b1;
        ks_valid   = 1'b0;
        if_state   = I_PROCESSING;
        tick();
        check("abort_ks_req_on", ks_req, 1'b1);
        if_state = I_IDLE;
        ks_valid = 1'b1;
        ks_data  = 8'h22;
        tick();
        check("abort_ks_req_off", ks_req, 1'b0);
        check("abort_ready", ready, 1'b0);
        check("abort_count", word_count, 16'd3);
        ks_valid = 1'b0;
        tick();
        check("abort_stays_idle", ks_req, 1'b0);

        // Asynchronous reset in the middle of a transaction.
        data_in    = 8'h33;
        encrypt_en = 1'b1;
        if_state   = I_PROCESSING;
        tick();
        check("mid_ks_req_on", ks_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_ks_req", ks_req, 1'b0);
        check("arst_ready", ready, 1'b0);
        check("arst_data_out", data_out, 8'h00);
        check("arst_word_count", word_count, 16'd0);
        exp_count = 16'd0;
        if_state  = I_IDLE;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ks_req", ks_req, 1'b0);

        // Sixteen transactions: 4-bit counter wraps back to 0.
        for (int i = 0; i < 16; i++) begin
            do_txn(8'(i * 17), i[0], 8'hC3);
        end
        check("wrap_count16", word_count, 16'd16);
        check("wrap_count4", word_count4, 4'd0);

        tick();
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
